// File: rtl/fifo_fwft_flush_if.sv
// Handshake bundle for fifo_fwft_flush: producer write side, consumer read side and status flags.
interface fifo_fwft_flush_if #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_NUM     = 8,
    parameter int DEPTH      = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                                 flush;
    logic [IN_NUM-1:0][DATA_WIDTH-1:0]    data_in;
    logic                                 data_in_valid;
    logic                                 data_in_ready;
    logic [IN_NUM-1:0][DATA_WIDTH-1:0]    data_out;
    logic                                 data_out_valid;
    logic                                 data_out_ready;
    logic [CNT_W-1:0]                     count;
    logic                                 almost_full;
    logic                                 almost_empty;

    modport master (
        output flush, data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid, count, almost_full, almost_empty
    );

    modport slave (
        input  flush, data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid, count, almost_full, almost_empty
    );
endinterface

// File: rtl/fifo_fwft_flush.sv
// First-word-fall-through FIFO: registered head entry backed by a (DEPTH-1)-entry RAM,
// arbitrary DEPTH, occupancy count, almost flags and synchronous flush.
module fifo_fwft_flush #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int IN_NUM     = 8,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_fwft_flush_if.slave     bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RAM_D = DEPTH - 1;
    localparam int PTR_W = (RAM_D > 1) ? $clog2(RAM_D) : 1;
    // A one-entry RAM still gets a 1-bit pointer, so pad the array to keep indexing legal.
    localparam int RAM_N = (RAM_D > 1) ? RAM_D : 2;

    typedef logic [IN_NUM-1:0][DATA_WIDTH-1:0] entry_t;

    entry_t           ram [RAM_N];
    entry_t           head_q, head_nxt;
    logic             head_vld_q, head_vld_nxt;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0] count_q, count_nxt;
    logic [CNT_W-1:0] ram_cnt;
    logic             ready_q, af_q, ae_q;
    logic             push, pop, ram_we, ram_empty, head_free;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RAM_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign bus.data_in_ready  = ready_q & ~bus.flush;
    assign bus.data_out       = head_q;
    assign bus.data_out_valid = head_vld_q;
    assign bus.count          = count_q;
    assign bus.almost_full    = af_q;
    assign bus.almost_empty   = ae_q;

    assign push      = bus.data_in_valid & bus.data_in_ready;
    assign pop       = head_vld_q & bus.data_out_ready;
    assign ram_cnt   = count_q - CNT_W'(head_vld_q);
    assign ram_empty = (ram_cnt == '0);
    assign head_free = ~head_vld_q | pop;

    always_comb begin
        head_nxt     = head_q;
        head_vld_nxt = head_vld_q;
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        count_nxt    = count_q;
        ram_we       = 1'b0;
        if (bus.flush) begin
            head_vld_nxt = 1'b0;
            wr_ptr_nxt   = '0;
            rd_ptr_nxt   = '0;
            count_nxt    = '0;
        end else begin
            if (head_free) begin
                if (!ram_empty) begin
                    head_nxt     = ram[rd_ptr];
                    head_vld_nxt = 1'b1;
                    rd_ptr_nxt   = ptr_inc(rd_ptr);
                end else if (push) begin
                    // Bypass: empty RAM, incoming entry goes straight to the head.
                    head_nxt     = bus.data_in;
                    head_vld_nxt = 1'b1;
                end else begin
                    head_vld_nxt = 1'b0;
                end
            end
            if (push && !(head_free && ram_empty)) begin
                ram_we     = 1'b1;
                wr_ptr_nxt = ptr_inc(wr_ptr);
            end
            if (push && !pop) begin
                count_nxt = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_nxt = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            head_vld_q <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
        end else begin
            head_q     <= head_nxt;
            head_vld_q <= head_vld_nxt;
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            count_q    <= count_nxt;
            ready_q    <= (count_nxt != CNT_W'(DEPTH));
            af_q       <= (count_nxt >= CNT_W'(AF_LEVEL));
            ae_q       <= (count_nxt <= CNT_W'(AE_LEVEL));
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[wr_ptr] <= bus.data_in;
        end
    end
endmodule

// File: tb/tb_fifo_fwft_flush.sv
// Bench for fifo_fwft_flush: four depths driven in lockstep, checked against a queue model.
module tb_fifo_fwft_flush;
    localparam int NI = 4;

    function automatic int dep_of(input int k);
        case (k)
            0:       return 8;
            1:       return 5;
            2:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int af_of(input int k);
        case (k)
            0:       return 6;
            1:       return 4;
            2:       return 2;
            default: return 2;
        endcase
    endfunction

    function automatic int ae_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            2:       return 0;
            default: return 1;
        endcase
    endfunction

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              vin;
    logic              ordy;
    logic [63:0]       din;
    logic [NI-1:0]     v_valid, v_ready, v_af, v_ae;
    logic [NI-1:0][3:0]  v_cnt;
    logic [NI-1:0][63:0] v_dout;

    int vectors;
    int errors;

    logic [63:0] mq [NI][16];
    int          mh [NI];
    int          mc [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int D  = dep_of(g);
        localparam int AF = af_of(g);
        localparam int AE = ae_of(g);

        fifo_fwft_flush_if #(.DATA_WIDTH(8), .IN_NUM(8), .DEPTH(D)) bus ();

        assign bus.flush          = flush;
        assign bus.data_in        = din;
        assign bus.data_in_valid  = vin;
        assign bus.data_out_ready = ordy;

        fifo_fwft_flush #(
            .DEPTH(D), .DATA_WIDTH(8), .IN_NUM(8), .AF_LEVEL(AF), .AE_LEVEL(AE)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign v_valid[g] = bus.data_out_valid;
        assign v_ready[g] = bus.data_in_ready;
        assign v_af[g]    = bus.almost_full;
        assign v_ae[g]    = bus.almost_empty;
        assign v_cnt[g]   = 4'(bus.count);
        assign v_dout[g]  = bus.data_out;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            mh[k] = 0;
            mc[k] = 0;
        end
    endtask

    task automatic compare_model();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("valid[%0d]", k), 64'(v_valid[k]), 64'(mc[k] > 0));
            chk($sformatf("count[%0d]", k), 64'(v_cnt[k]), 64'(mc[k]));
            chk($sformatf("in_ready[%0d]", k), 64'(v_ready[k]),
                64'((mc[k] != dep_of(k)) && !flush));
            chk($sformatf("almost_full[%0d]", k), 64'(v_af[k]), 64'(mc[k] >= af_of(k)));
            chk($sformatf("almost_empty[%0d]", k), 64'(v_ae[k]), 64'(mc[k] <= ae_of(k)));
            if (mc[k] > 0)
                chk($sformatf("data_out[%0d]", k), v_dout[k], mq[k][mh[k]]);
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < NI; k++) begin
            if (flush) begin
                mh[k] = 0;
                mc[k] = 0;
            end else begin
                bit do_push;
                bit do_pop;
                do_push = vin && (mc[k] != dep_of(k));
                do_pop  = (mc[k] > 0) && ordy;
                if (do_pop) begin
                    mh[k] = (mh[k] + 1) % 16;
                    mc[k] = mc[k] - 1;
                end
                if (do_push) begin
                    mq[k][(mh[k] + mc[k]) % 16] = din;
                    mc[k] = mc[k] + 1;
                end
            end
        end
    endtask

    // Entered and left at posedge+1: drive, check at the falling edge, advance model, clock.
    task automatic step(input logic fl, input logic v, input logic [63:0] d, input logic r);
        flush = fl;
        vin   = v;
        din   = d;
        ordy  = r;
        @(negedge clk);
        compare_model();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst   = 1'b0;
        flush = 1'b0;
        vin   = 1'b0;
        ordy  = 1'b0;
        din   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step(0, 0, '0, 0);

        // First-word fall-through on empty FIFO
        step(0, 1, {8{8'hA5}}, 0);
        chk("fwft_valid", 64'(v_valid[0]), 64'd1);
        chk("fwft_data", v_dout[0], 64'hA5A5_A5A5_A5A5_A5A5);
        chk("fwft_count", 64'(v_cnt[0]), 64'd1);

        // Fill past capacity with consumer stalled, then drain
        step(1, 0, '0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, {8{8'(i)}}, 0);
        chk("fill_count5", 64'(v_cnt[1]), 64'd5);
        chk("fill_ready5", 64'(v_ready[1]), 64'd0);
        chk("fill_af5", 64'(v_af[1]), 64'd1);
        chk("fill_count8", 64'(v_cnt[0]), 64'd7);
        chk("fill_count2", 64'(v_cnt[2]), 64'd2);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("drain_data%0d", i), v_dout[1], {8{8'(i)}});
            chk($sformatf("drain_count%0d", i), 64'(v_cnt[1]), 64'(5 - i));
            step(0, 0, '0, 1);
        end
        chk("drain_empty_count", 64'(v_cnt[1]), 64'd0);
        chk("drain_empty_valid", 64'(v_valid[1]), 64'd0);
        chk("drain_ae", 64'(v_ae[1]), 64'd1);

        // Flush with a simultaneous push discards everything
        step(1, 0, '0, 0);
        step(0, 1, {8{8'h11}}, 0);
        step(0, 1, {8{8'h22}}, 0);
        step(0, 1, {8{8'h33}}, 0);
        chk("pre_flush_count", 64'(v_cnt[0]), 64'd3);
        step(1, 1, {8{8'hEE}}, 0);
        chk("flush_count", 64'(v_cnt[0]), 64'd0);
        chk("flush_valid", 64'(v_valid[0]), 64'd0);
        step(0, 1, {8{8'h44}}, 0);
        chk("post_flush_data", v_dout[0], {8{8'h44}});
        chk("post_flush_count", 64'(v_cnt[0]), 64'd1);

        // Streaming: one push and one pop per cycle at constant occupancy
        step(1, 0, '0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 64'(i + 'h100), 0);
        for (int i = 0; i < 100; i++) begin
            step(0, 1, 64'(i + 'h200), 1);
            chk("stream_count", 64'(v_cnt[0]), 64'd3);
            chk("stream_valid", 64'(v_valid[0]), 64'd1);
        end

        // Random valid/ready with occasional flush
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, ($urandom_range(0, 2) != 0));
        end

        // Reset mid-transfer takes effect without a clock edge
        step(0, 1, 64'h0123_4567_89AB_CDEF, 0);
        step(0, 1, 64'hFEDC_BA98_7654_3210, 0);
        vin = 1'b0;
        rst = 1'b0;
        #2;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst_valid[%0d]", k), 64'(v_valid[k]), 64'd0);
            chk($sformatf("rst_count[%0d]", k), 64'(v_cnt[k]), 64'd0);
            chk($sformatf("rst_ready[%0d]", k), 64'(v_ready[k]), 64'd1);
            chk($sformatf("rst_af[%0d]", k), 64'(v_af[k]), 64'd0);
            chk($sformatf("rst_ae[%0d]", k), 64'(v_ae[k]), 64'd1);
            chk($sformatf("rst_data[%0d]", k), v_dout[k], 64'd0);
        end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        step(0, 1, {8{8'h5A}}, 0);
        chk("after_rst_data", v_dout[2], {8{8'h5A}});
        for (int i = 0; i < 6; i++) step(0, 1, 64'(i), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
